// File: rtl/sram_arb_pkg.sv
// ============================================================================
//  Module   : sram_arb_pkg
//  Brief    : Shared widths, FSM state encoding and write-entry layout for the
//             SRAM arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    localparam int SRAM_AW    = 18;
    localparam int SRAM_DW    = 16;
    localparam int WR_ENTRY_W = SRAM_AW + SRAM_DW;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_SETUP = 2'd1,
        WR_PULSE = 2'd2,
        WR_HOLD  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
    } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/sram_wr_fifo.sv
// ============================================================================
//  Module   : sram_wr_fifo
//  Brief    : Synchronous FIFO of buffered SRAM write entries with occupancy.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_wr_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WR_ENTRY_W-1:0] din_i,
    output logic [WR_ENTRY_W-1:0] head_o,
    output logic [PW:0]           count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WR_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [PW:0]           count_q;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module   : sram_arbiter
//  Brief    : Single-port SRAM arbiter: fixed-latency display reads, FIFO-
//             buffered game-logic writes. SRAM_ARB_STATS_EN adds counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WFIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_pre,
    input  logic               rd_req,
    input  logic [SRAM_AW-1:0] rd_addr,
    output logic               rd_valid,
    output logic [SRAM_DW-1:0] rd_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [SRAM_AW-1:0] wr_addr,
    input  logic [SRAM_DW-1:0] wr_data,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               err_collision
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]        stat_writes,
    output logic [6:0]         stat_max_fill
`endif
);

    localparam int PW = $clog2(WFIFO_DEPTH);

    arb_state_e         state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic               rd_pend_q, rd_pend_d;
    logic               hold_v_q, hold_v_d;
    logic [SRAM_AW-1:0] hold_addr_q, hold_addr_d;
    logic               err_q, err_d;
    logic               rd_valid_q;
    logic [SRAM_DW-1:0] rd_data_q;

    logic               w_push;
    logic               w_pop;
    wr_entry_t          w_din;
    wr_entry_t          w_head;
    logic [PW:0]        w_count;
    logic               w_full;
    logic               w_empty;

    assign w_din    = '{addr: wr_addr, data: wr_data};
    assign wr_ready = rst_n & ~w_full;
    assign w_push   = wr_valid & wr_ready;

    sram_wr_fifo #(
        .DEPTH   (WFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;
        dq_oe_d     = dq_oe_q;
        wdata_d     = wdata_q;
        rd_pend_d   = 1'b0;
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        err_d       = err_q;
        w_pop       = 1'b0;

        case (state_q)
            IDLE: begin
                // A read held over from a write wins over both new reads and writes.
                if (hold_v_q) begin
                    addr_d      = hold_addr_q;
                    oe_n_d      = 1'b0;
                    rd_pend_d   = 1'b1;
                    hold_v_d    = rd_req;
                    hold_addr_d = rd_addr;
                end else if (rd_req) begin
                    addr_d    = rd_addr;
                    oe_n_d    = 1'b0;
                    rd_pend_d = 1'b1;
                end else if (!disp_pre && !w_empty) begin
                    w_pop   = 1'b1;
                    addr_d  = w_head.addr;
                    wdata_d = w_head.data;
                    oe_n_d  = 1'b1;
                    state_d = WR_SETUP;
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                we_n_d  = 1'b1;
                state_d = WR_HOLD;
            end
            WR_HOLD: begin
                dq_oe_d = 1'b0;
                oe_n_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && rd_req) begin
            err_d       = 1'b1;
            hold_v_d    = 1'b1;
            hold_addr_d = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
            dq_oe_q     <= 1'b0;
            wdata_q     <= '0;
            rd_pend_q   <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            wdata_q     <= wdata_d;
            rd_pend_q   <= rd_pend_d;
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= sram_dq;
            end
        end
    end

    assign sram_addr     = addr_q;
    assign sram_we_n     = we_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_dq       = dq_oe_q ? wdata_q : {SRAM_DW{1'bz}};
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign err_collision = err_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_writes_q;
    logic [6:0]  stat_max_fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_writes_q   <= '0;
            stat_max_fill_q <= '0;
        end else begin
            if (state_q == WR_HOLD) begin
                stat_writes_q <= stat_writes_q + 16'd1;
            end
            if (7'(w_count) > stat_max_fill_q) begin
                stat_max_fill_q <= 7'(w_count);
            end
        end
    end

    assign stat_writes   = stat_writes_q;
    assign stat_max_fill = stat_max_fill_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
//  Module   : tb_sram_arbiter
//  Brief    : Directed vector bench for sram_arbiter with a behavioural SRAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_pre;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        err_collision;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_writes;
    logic [6:0]  stat_max_fill;
`endif

    int n_chk  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .WFIFO_DEPTH   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .disp_pre      (disp_pre),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .sram_addr     (sram_addr),
        .sram_dq       (sram_dq),
        .sram_we_n     (sram_we_n),
        .sram_oe_n     (sram_oe_n),
        .err_collision (err_collision)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stat_writes   (stat_writes),
        .stat_max_fill (stat_max_fill)
`endif
    );

    // SRAM model: unwritten words read back their own low address bits.
    logic [15:0] mem   [262144];
    logic        wflag [262144];
    logic [15:0] model_rd;

    always_comb begin
        model_rd = sram_addr[15:0];
        if (wflag[sram_addr]) begin
            model_rd = mem[sram_addr];
        end
    end

    assign sram_dq = (!sram_oe_n && sram_we_n && rst_n) ? model_rd : 16'hzzzz;

    always @(posedge clk) begin
        if (rst_n && !sram_we_n) begin
            mem[sram_addr]   <= sram_dq;
            wflag[sram_addr] <= 1'b1;
        end
    end

    typedef struct packed {
        logic        rd_req;
        logic [17:0] rd_addr;
        logic        disp_pre;
        logic        wr_valid;
        logic [17:0] wr_addr;
        logic [15:0] wr_data;
        logic        e_rd_valid;
        logic [15:0] e_rd_data;
        logic [17:0] e_addr;
        logic        e_we_n;
        logic        e_oe_n;
        logic        e_dq_chk;
        logic [15:0] e_dq;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int we_low;

    initial begin
        rst_n    = 1'b0;
        disp_pre = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        //        rd  rd_addr    dp  wv  wr_addr    wr_data   ev  e_data    e_addr     we  oe  dqc e_dq
        vt[0]  = '{1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0000, 18'h00010, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[1]  = '{1'b1, 18'h00011, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 16'h0010, 18'h00011, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[2]  = '{1'b1, 18'h00012, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 16'h0011, 18'h00012, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[3]  = '{1'b1, 18'h00013, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 16'h0012, 18'h00013, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[4]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 16'h0013, 18'h00013, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[5]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h00013, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[6]  = '{1'b0, 18'h00000, 1'b0, 1'b1, 18'h12345, 16'hBEEF, 1'b0, 16'h0013, 18'h00013, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[7]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h12345, 1'b1, 1'b1, 1'b0, 16'h0};
        vt[8]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h12345, 1'b0, 1'b1, 1'b1, 16'hBEEF};
        vt[9]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h12345, 1'b1, 1'b1, 1'b1, 16'hBEEF};
        vt[10] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h12345, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[11] = '{1'b1, 18'h12345, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 16'h0013, 18'h12345, 1'b1, 1'b0, 1'b0, 16'h0};
        vt[12] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 16'hBEEF, 18'h12345, 1'b1, 1'b0, 1'b0, 16'h0};

        // Reset values while rst_n is held low
        tick();
        chk("rst_addr",     32'(sram_addr),     32'h0);
        chk("rst_we_n",     32'(sram_we_n),     32'h1);
        chk("rst_oe_n",     32'(sram_oe_n),     32'h0);
        chk("rst_rd_valid", 32'(rd_valid),      32'h0);
        chk("rst_rd_data",  32'(rd_data),       32'h0);
        chk("rst_err",      32'(err_collision), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready),      32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);

        // Read stream and single write retire
        for (int i = 0; i < 13; i++) begin
            rd_req   = vt[i].rd_req;
            rd_addr  = vt[i].rd_addr;
            disp_pre = vt[i].disp_pre;
            wr_valid = vt[i].wr_valid;
            wr_addr  = vt[i].wr_addr;
            wr_data  = vt[i].wr_data;
            tick();
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid),  32'(vt[i].e_rd_valid));
            chk($sformatf("v%0d_rd_data", i),  32'(rd_data),   32'(vt[i].e_rd_data));
            chk($sformatf("v%0d_addr", i),     32'(sram_addr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_we_n", i),     32'(sram_we_n), 32'(vt[i].e_we_n));
            chk($sformatf("v%0d_oe_n", i),     32'(sram_oe_n), 32'(vt[i].e_oe_n));
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready),  32'h1);
            chk($sformatf("v%0d_err", i),      32'(err_collision), 32'h0);
            if (vt[i].e_dq_chk) begin
                chk($sformatf("v%0d_dq", i), 32'(sram_dq), 32'(vt[i].e_dq));
            end
        end
        rd_req = 1'b0;

        // Inhibit: fill the FIFO under disp_pre, then drain in 32 cycles
        disp_pre = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 18'h00100 + 18'(i);
            wr_data  = 16'hA000 + 16'(i);
            tick();
            chk($sformatf("inh_ready_%0d", i), 32'(wr_ready), (i == 7) ? 32'h0 : 32'h1);
            chk($sformatf("inh_we_n_%0d", i),  32'(sram_we_n), 32'h1);
        end
        wr_valid = 1'b0;
        tick();
        chk("inh_hold_we_n",  32'(sram_we_n), 32'h1);
        chk("inh_hold_ready", 32'(wr_ready),  32'h0);
        disp_pre = 1'b0;
        we_low   = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (!sram_we_n) we_low++;
            if (k == 1) begin
                chk("drain_ready_first_pop", 32'(wr_ready),  32'h1);
                chk("drain_first_addr",      32'(sram_addr), 32'h00100);
            end
            if (k == 31) chk("drain_hold_oe_n", 32'(sram_oe_n), 32'h1);
            if (k == 32) chk("drain_idle_oe_n", 32'(sram_oe_n), 32'h0);
        end
        chk("drain_write_pulses", 32'(we_low), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_mem_%0d", i), 32'(mem[18'h00100 + 18'(i)]), 32'hA000 + 32'(i));
        end
        tick();
        chk("drain_no_extra_write", 32'(sram_we_n), 32'h1);

        // Collision: read arrives while the write sits in WR_SETUP
        wr_valid = 1'b1;
        wr_addr  = 18'h00200;
        wr_data  = 16'h1234;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("col_setup_oe_n", 32'(sram_oe_n), 32'h1);
        chk("col_setup_we_n", 32'(sram_we_n), 32'h1);
        rd_req  = 1'b1;
        rd_addr = 18'h00020;
        tick();
        rd_req = 1'b0;
        chk("col_err",        32'(err_collision), 32'h1);
        chk("col_pulse_we_n", 32'(sram_we_n),     32'h0);
        tick();
        tick();
        chk("col_idle_oe_n",     32'(sram_oe_n), 32'h0);
        chk("col_idle_rd_valid", 32'(rd_valid),  32'h0);
        tick();
        chk("col_held_addr",  32'(sram_addr), 32'h00020);
        chk("col_held_valid", 32'(rd_valid),  32'h0);
        tick();
        chk("col_rd_valid",   32'(rd_valid),      32'h1);
        chk("col_rd_data",    32'(rd_data),       32'h0020);
        chk("col_err_sticky", 32'(err_collision), 32'h1);
        chk("col_mem_write",  32'(mem[18'h00200]), 32'h1234);

        // Reset during WR_PULSE, with a second entry still buffered
        wr_valid = 1'b1;
        wr_addr  = 18'h00300;
        wr_data  = 16'hBEEF;
        tick();
        wr_addr  = 18'h00301;
        wr_data  = 16'h5555;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rmw_pulse_we_n", 32'(sram_we_n), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw_async_we_n",    32'(sram_we_n), 32'h1);
        chk("rmw_async_dq_rel",  32'(sram_dq !== 16'hBEEF), 32'h1);
        chk("rmw_async_ready",   32'(wr_ready),  32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rmw_release_ready", 32'(wr_ready),      32'h1);
        chk("rmw_release_err",   32'(err_collision), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rmw_empty_we_n_%0d", k), 32'(sram_we_n), 32'h1);
            chk($sformatf("rmw_empty_oe_n_%0d", k), 32'(sram_oe_n), 32'h0);
        end

`ifdef SRAM_ARB_STATS_EN
        // Counters: state is fresh after the reset above
        disp_pre = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 18'h00400 + 18'(i);
            wr_data  = 16'hC000 + 16'(i);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        chk("stat_max_fill", 32'(stat_max_fill), 32'd5);
        chk("stat_writes_0", 32'(stat_writes),   32'd0);
        disp_pre = 1'b0;
        for (int k = 0; k < 24; k++) tick();
        chk("stat_writes_5",    32'(stat_writes),   32'd5);
        chk("stat_max_fill_pk", 32'(stat_max_fill), 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
